alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes an RV32 ALU/branch op, drives the ALU,
// captures its result and returns it over a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       Funct3,
    input  logic             Funct7b5,
    input  logic [31:0]      RS1,
    input  logic [31:0]      RS2,
    input  logic [31:0]      Imm,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic [3:0]       ALUControl,
    input  logic [31:0]      ALUResult,
    input  logic             ALUZero,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      OutResult,
    output logic             BranchTaken,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] OpCount
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_br;
    logic        r_bne;
    logic        r_ill;

    logic [3:0]  w_ctrl;
    logic [31:0] w_b;
    logic        w_br;
    logic        w_bne;
    logic        w_ill;

    assign InReady = (r_state == S_IDLE);

    always_comb begin
        w_ctrl = 4'b1111;
        w_b    = RS2;
        w_br   = 1'b0;
        w_bne  = 1'b0;
        w_ill  = 1'b1;
        unique case (Opcode)
            OP_R, OP_I: begin
                w_b   = (Opcode == OP_I) ? Imm : RS2;
                w_ill = 1'b0;
                unique case (Funct3)
                    3'b000: w_ctrl = (Opcode == OP_R && Funct7b5) ?
                                     4'b0110 : 4'b0010;
                    3'b111: w_ctrl = 4'b0000;
                    3'b110: w_ctrl = 4'b0001;
                    3'b100: w_ctrl = 4'b0011;
                    3'b001: w_ctrl = 4'b1000;
                    3'b101: w_ctrl = Funct7b5 ? 4'b1010 : 4'b1001;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_BR: begin
                unique case (Funct3)
                    3'b000, 3'b001: begin
                        w_ctrl = 4'b0110;
                        w_br   = 1'b1;
                        w_bne  = Funct3[0];
                        w_ill  = 1'b0;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_br        <= 1'b0;
            r_bne       <= 1'b0;
            r_ill       <= 1'b0;
            A           <= '0;
            B           <= '0;
            ALUControl  <= 4'b0000;
            OutValid    <= 1'b0;
            OutResult   <= '0;
            BranchTaken <= 1'b0;
            IllegalOp   <= 1'b0;
            OpCount     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (InValid) begin
                        A          <= RS1;
                        B          <= w_b;
                        ALUControl <= w_ctrl;
                        r_br       <= w_br;
                        r_bne      <= w_bne;
                        r_ill      <= w_ill;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Illegal ops still complete, but never leak ALU garbage.
                    OutResult   <= r_ill ? '0 : ALUResult;
                    BranchTaken <= r_br & (ALUZero ^ r_bne);
                    IllegalOp   <= r_ill;
                    OutValid    <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        OpCount  <= OpCount + CNT_W'(1);
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
